hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Those registers hold when en=1 and zero themselves when clr=1 with en=0.
- Generates the forwarding selects.
- Tracks the multi-cycle mult/div unit with an internal busy FSM.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
MULT_CYCLES, 5, cycles HI/LO is busy after a mult/multu leaves E
DIV_CYCLES, 10, cycles HI/LO is busy after a div/divu leaves E
CNT_W, 4, width of the busy down-counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset; one clock, synchronous, active-high
RsD  input  5  rs field of the instruction in D
RtD  input  5  rt field of the instruction in D
UseRsD  input  1  instruction in D reads rs
UseRtD  input  1  instruction in D reads rt
BranchD  input  1  instruction in D is a branch; it compares in D
MdUseD  input  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
RsE  input  5  rs of the instruction in E
RtE  input  5  rt of the instruction in E
RegAddrE  input  5  destination register of the instruction in E
RegWriteE  input  1  instruction in E writes the register file
MemtoRegE  input  1  instruction in E is a load
MdStartE  input  1  mult/div is in E this cycle
MdDivE  input  1  with MdStartE: 1=div, 0=mult
RegAddrM  input  5  destination register in M
RegWriteM  input  1  instruction in M writes the register file
MemtoRegM  input  1  instruction in M is a load
RegAddrW  input  5  destination register in W
RegWriteW  input  1  instruction in W writes the register file
StallF  output  1  hold the PC
StallD  output  1  en of IF/ID (1=hold)
FlushE  output  1  clr of ID/EX (insert bubble)
ForwardAD  output  1  rs compare operand taken from ALUResM
ForwardBD  output  1  rt compare operand taken from ALUResM
ForwardAE  output  2  ALU A source: 00 regfile, 01 W result, 10 ALUResM
ForwardBE  output  2  ALU B source, same encoding as ForwardAE
MdBusy  output  1  HI/LO unit busy
StallCnt  output  32  total stalled cycles since reset, saturating

Behaviour:
- Register $0 never matches: every hazard and forward compare requires the address to be nonzero.
- lwstall = MemtoRegE & RegWriteE & ((UseRsD & RsD==RegAddrE) | (UseRtD & RtD==RegAddrE)).
- brstall = BranchD & ((RegWriteE & RegAddrE∈{RsD,RtD}) | (MemtoRegM & RegAddrM∈{RsD,RtD})).
- mdstall = MdUseD & (MdBusy | MdStartE).
- stall = lwstall | brstall | mdstall.
- StallF = StallD = FlushE = stall. All are combinational, with no added latency.
- ForwardAE: 10 if RegWriteM & RegAddrM==RsE; else 01 if RegWriteW & RegAddrW==RsE; else 00. M has priority over W. ForwardBE is the same using RtE.
- ForwardAD = RegWriteM & RegAddrM==RsD. ForwardBD is the same using RtD.
- Busy FSM has two states, IDLE and BUSY, with a counter cnt[CNT_W-1:0]:
  - IDLE with MdStartE: go to BUSY and set cnt = (MdDivE ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY with cnt==0: go to IDLE. Otherwise decrement cnt.
  - MdStartE while already BUSY: reload cnt with the new op's value and stay BUSY. The new op overrides.
  - MdBusy = (state==BUSY). It rises the cycle after MdStartE and stays high for exactly N cycles.
- StallCnt increments by 1 on each clock edge where stall=1. It saturates at 0xFFFFFFFF.
- Reset (synchronous, takes effect on that edge, including mid-BUSY):
  - state=IDLE, cnt=0, StallCnt=0.
  - During the reset cycle, combinational outputs still follow the inputs with MdBusy=0.
- Simultaneous hazards: any combination yields a single stall cycle per clock. There is no priority among stall causes.

Decomposition:
- Shared macro header: forward-select encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the FSM state encodings.
- One sub-module, md_busy_tracker, holds the FSM and the down-counter.
- Stall/forward logic and StallCnt stay in hazard_ctrl.

Test Plan:
1. Load-use: E is lw to $8 (MemtoRegE=1, RegWriteE=1, RegAddrE=8); D has UseRsD=1, RsD=8 -> StallF=StallD=FlushE=1 for one cycle, StallCnt=1. Next cycle with E a bubble -> no stall.
2. Forwarding priority: RegWriteM=1, RegAddrM=5; RegWriteW=1, RegAddrW=5; RsE=5 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set RsE=0 -> ForwardAE=00.
3. Branch hazard: BranchD=1, RsD=3, RegWriteE=1, RegAddrE=3 -> stall. Next cycle (RegAddrM=3, RegWriteM=1, MemtoRegM=0) -> no stall, ForwardAD=1.
4. Div busy: MdStartE=1, MdDivE=1 at cycle t -> MdBusy high for cycles t+1..t+10. MdUseD=1 throughout -> stall at cycles t..t+10, StallCnt=11.
5. Reset mid-BUSY: mult started, reset at the 2nd busy cycle -> next cycle MdBusy=0, StallCnt=0, no stall with MdUseD=1.
6. $0 immunity: lw to $0 in E, RsD=0, UseRsD=1 -> no stall. RegAddrM=0, RsE=0 -> ForwardAE=00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects,
// mult/div busy FSM states and the register-compare helper.
package hazard_ctrl_pkg;

    // Forwarding select encodings for the E-stage ALU operand muxes
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A producer matches a consumer only when it writes, the addresses agree
    // and the register is not $0 (which is hard-wired to zero).
    function automatic logic reg_hit(input logic we, input logic [4:0] dst,
                                     input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Busy tracker for the multi-cycle HI/LO unit. busy_o rises the cycle
// after start_i and stays high for exactly the op's cycle count; a new
// start while busy reloads the counter with the new op's length.
module md_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Busy FSM with down-counter; start has priority so a new op overrides
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= div_i ? DIV_LOAD : MULT_LOAD;
            busy_q  <= 1'b1;
        end else if (state_q == MD_BUSY) begin
            if (cnt_q == '0) begin
                state_q <= MD_IDLE;
                busy_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// generation, forwarding selects, HI/LO busy tracking and a saturating
// stalled-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        UseRsD,
    input  logic        UseRtD,
    input  logic        BranchD,
    input  logic        MdUseD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RegAddrE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MdStartE,
    input  logic        MdDivE,
    input  logic [4:0]  RegAddrM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [4:0]  RegAddrW,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MdBusy,
    output logic [31:0] StallCnt
);

    logic        md_busy;
    logic        lwstall, brstall, mdstall, stall;
    logic [31:0] stall_cnt_q;

    md_busy_tracker #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .start_i(MdStartE),
        .div_i  (MdDivE),
        .busy_o (md_busy)
    );

    // The busy flag reads as clear during the reset cycle so that a pending
    // HI/LO op cannot stall the pipe while it is being reset.
    assign MdBusy = md_busy & ~reset;

    // Stall causes are independent; any combination gives one stall cycle
    always_comb begin
        lwstall = MemtoRegE & RegWriteE &
                  ((UseRsD & reg_hit(1'b1, RegAddrE, RsD)) |
                   (UseRtD & reg_hit(1'b1, RegAddrE, RtD)));
        brstall = BranchD &
                  (reg_hit(RegWriteE, RegAddrE, RsD) | reg_hit(RegWriteE, RegAddrE, RtD) |
                   reg_hit(MemtoRegM, RegAddrM, RsD) | reg_hit(MemtoRegM, RegAddrM, RtD));
        mdstall = MdUseD & (MdBusy | MdStartE);
        stall   = lwstall | brstall | mdstall;
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // Forwarding selects; the younger result in M wins over W
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reg_hit(RegWriteM, RegAddrM, RsE))      ForwardAE = FWD_M;
        else if (reg_hit(RegWriteW, RegAddrW, RsE)) ForwardAE = FWD_W;
        if (reg_hit(RegWriteM, RegAddrM, RtE))      ForwardBE = FWD_M;
        else if (reg_hit(RegWriteW, RegAddrW, RtE)) ForwardBE = FWD_W;
        ForwardAD = reg_hit(RegWriteM, RegAddrM, RsD);
        ForwardBD = reg_hit(RegWriteM, RegAddrM, RtD);
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected values are pushed to a queue
// as stimulus is applied and popped for comparison at the falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW;
    logic        UseRsD, UseRtD, BranchD, MdUseD;
    logic        RegWriteE, MemtoRegE, MdStartE, MdDivE;
    logic        RegWriteM, MemtoRegM, RegWriteW;
    logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt;

    typedef struct {
        logic        stall;
        logic        fad;
        logic        fbd;
        logic [1:0]  fae;
        logic [1:0]  fbe;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mcnt     = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
        .BranchD(BranchD), .MdUseD(MdUseD),
        .RsE(RsE), .RtE(RtE), .RegAddrE(RegAddrE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MdStartE(MdStartE), .MdDivE(MdDivE),
        .RegAddrM(RegAddrM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .RegAddrW(RegAddrW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        RsD = 0; RtD = 0; UseRsD = 0; UseRtD = 0; BranchD = 0; MdUseD = 0;
        RsE = 0; RtE = 0; RegAddrE = 0; RegWriteE = 0; MemtoRegE = 0;
        MdStartE = 0; MdDivE = 0; RegAddrM = 0; RegWriteM = 0; MemtoRegM = 0;
        RegAddrW = 0; RegWriteW = 0;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mcnt  = 0;
    endtask

    task automatic next_cycle(input logic stalled);
        if (stalled) mcnt = mcnt + 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        pulse_reset();
        e = '{stall:0, fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:0, cnt:mcnt};
        exp_q.push_back(e);
        #4;
        e = exp_q.pop_front();
        checks++; if (StallCnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", StallCnt); end
        checks++; if (MdBusy !== e.busy) begin failures++; $display("FAIL rst_busy got=%b exp=%b", MdBusy, e.busy); end
        checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL rst_stall got=%b exp=%b", {StallF, StallD, FlushE}, {3{e.stall}}); end
        checks++; if ({ForwardAE, ForwardBE} !== {e.fae, e.fbe}) begin failures++; $display("FAIL rst_fwd got=%b exp=%b", {ForwardAE, ForwardBE}, {e.fae, e.fbe}); end
        next_cycle(e.stall);
    endtask

    // lw in E against rs/rt in D, the Use gating, then a bubble
    task automatic test_load_use;
        logic ex[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        clear_inputs();
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin MemtoRegE = 1; RegWriteE = 1; RegAddrE = 8; UseRsD = 1; RsD = 8; end
                1: begin UseRsD = 1; RsD = 8; end
                2: begin MemtoRegE = 1; RegWriteE = 1; RegAddrE = 9; UseRtD = 1; RtD = 9; RsD = 3; end
                3: begin MemtoRegE = 1; RegWriteE = 1; RegAddrE = 9; UseRsD = 1; UseRtD = 1; RsD = 9; RtD = 9; end
                default: begin MemtoRegE = 1; RegWriteE = 1; RegAddrE = 9; UseRtD = 0; RtD = 9; end
            endcase
            e = '{stall:ex[c], fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:0, cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL lu_stall c=%0d got=%b exp=%b", c, {StallF, StallD, FlushE}, {3{e.stall}}); end
            checks++; if (StallCnt !== e.cnt) begin failures++; $display("FAIL lu_cnt c=%0d got=%0d exp=%0d", c, StallCnt, e.cnt); end
            next_cycle(e.stall);
        end
        checks++; if (StallCnt !== 32'd3) begin failures++; $display("FAIL lu_total got=%0d exp=3", StallCnt); end
    endtask

    // M over W priority on both ALU operands
    task automatic test_forward;
        logic [1:0] ea[4] = '{2'b10, 2'b01, 2'b00, 2'b00};
        logic [1:0] eb[4] = '{2'b10, 2'b01, 2'b01, 2'b10};
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin RegWriteM = 1; RegAddrM = 5; RegWriteW = 1; RegAddrW = 5; RsE = 5; RtE = 5; end
                1: begin RegWriteM = 0; end
                2: begin RsE = 0; end
                default: begin RegWriteM = 1; RegAddrM = 7; RtE = 7; RsE = 6; end
            endcase
            e = '{stall:0, fad:0, fbd:0, fae:ea[c], fbe:eb[c], busy:0, cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if (ForwardAE !== e.fae) begin failures++; $display("FAIL fwd_ae c=%0d got=%b exp=%b", c, ForwardAE, e.fae); end
            checks++; if (ForwardBE !== e.fbe) begin failures++; $display("FAIL fwd_be c=%0d got=%b exp=%b", c, ForwardBE, e.fbe); end
            next_cycle(e.stall);
        end
    endtask

    // Branch compares in D: E producer stalls, M ALU result forwards, M load stalls
    task automatic test_branch;
        logic es[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic ea[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic eb[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin BranchD = 1; RsD = 3; RegWriteE = 1; RegAddrE = 3; end
                1: begin BranchD = 1; RsD = 3; RegWriteM = 1; RegAddrM = 3; end
                2: begin BranchD = 1; RsD = 4; RtD = 3; RegWriteM = 1; MemtoRegM = 1; RegAddrM = 3; end
                default: begin RsD = 3; RegWriteE = 1; RegAddrE = 3; end
            endcase
            e = '{stall:es[c], fad:ea[c], fbd:eb[c], fae:2'b00, fbe:2'b00, busy:0, cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL br_stall c=%0d got=%b exp=%b", c, {StallF, StallD, FlushE}, {3{e.stall}}); end
            checks++; if ({ForwardAD, ForwardBD} !== {e.fad, e.fbd}) begin failures++; $display("FAIL br_fwd c=%0d got=%b exp=%b", c, {ForwardAD, ForwardBD}, {e.fad, e.fbd}); end
            checks++; if (StallCnt !== e.cnt) begin failures++; $display("FAIL br_cnt c=%0d got=%0d exp=%0d", c, StallCnt, e.cnt); end
            next_cycle(e.stall);
        end
    endtask

    // div at c=0 with MdUseD held: busy c=1..10, stall c=0..10
    task automatic test_div;
        clear_inputs();
        pulse_reset();
        MdUseD = 1;
        for (int c = 0; c < 12; c++) begin
            MdStartE = (c == 0);
            MdDivE   = (c == 0);
            e = '{stall:(c <= 10), fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:(c >= 1 && c <= 10), cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if (MdBusy !== e.busy) begin failures++; $display("FAIL div_busy c=%0d got=%b exp=%b", c, MdBusy, e.busy); end
            checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL div_stall c=%0d got=%b exp=%b", c, {StallF, StallD, FlushE}, {3{e.stall}}); end
            checks++; if (StallCnt !== e.cnt) begin failures++; $display("FAIL div_cnt c=%0d got=%0d exp=%0d", c, StallCnt, e.cnt); end
            next_cycle(e.stall);
        end
        checks++; if (StallCnt !== 32'd11) begin failures++; $display("FAIL div_total got=%0d exp=11", StallCnt); end
    endtask

    // mult at c=0 (busy 1..5) overridden by div at c=2 (busy 3..12)
    task automatic test_back_to_back;
        clear_inputs();
        pulse_reset();
        for (int c = 0; c < 15; c++) begin
            MdStartE = (c == 0 || c == 2);
            MdDivE   = (c == 2);
            e = '{stall:0, fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:(c >= 1 && c <= 12), cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if (MdBusy !== e.busy) begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, MdBusy, e.busy); end
            next_cycle(e.stall);
        end
        // lone mult: busy exactly 5 cycles
        for (int c = 0; c < 7; c++) begin
            MdStartE = (c == 0);
            MdDivE   = 0;
            e = '{stall:0, fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:(c >= 1 && c <= 5), cnt:mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if (MdBusy !== e.busy) begin failures++; $display("FAIL mul_busy c=%0d got=%b exp=%b", c, MdBusy, e.busy); end
            next_cycle(e.stall);
        end
    endtask

    // reset asserted during the 2nd busy cycle of a mult
    task automatic test_reset_mid_busy;
        logic eb[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic es[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_inputs();
        pulse_reset();
        MdUseD = 1;
        for (int c = 0; c < 5; c++) begin
            MdStartE = (c == 0);
            reset    = (c == 2);
            e = '{stall:es[c], fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:eb[c], cnt:(c >= 3) ? 32'd0 : mcnt};
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            checks++; if (MdBusy !== e.busy) begin failures++; $display("FAIL rmb_busy c=%0d got=%b exp=%b", c, MdBusy, e.busy); end
            checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL rmb_stall c=%0d got=%b exp=%b", c, {StallF, StallD, FlushE}, {3{e.stall}}); end
            checks++; if (StallCnt !== e.cnt) begin failures++; $display("FAIL rmb_cnt c=%0d got=%0d exp=%0d", c, StallCnt, e.cnt); end
            next_cycle(e.stall && !reset);
            if (c == 2) begin reset = 1'b0; mcnt = 0; end
        end
        reset = 1'b0;
    endtask

    // register $0 never produces a hazard or a forward
    task automatic test_zero_reg;
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; RegAddrE = 0; UseRsD = 1; UseRtD = 1; BranchD = 1;
        RegWriteM = 1; MemtoRegM = 1; RegAddrM = 0; RegWriteW = 1; RegAddrW = 0;
        e = '{stall:0, fad:0, fbd:0, fae:2'b00, fbe:2'b00, busy:0, cnt:mcnt};
        exp_q.push_back(e);
        #4;
        e = exp_q.pop_front();
        checks++; if ({StallF, StallD, FlushE} !== {3{e.stall}}) begin failures++; $display("FAIL z_stall got=%b exp=%b", {StallF, StallD, FlushE}, {3{e.stall}}); end
        checks++; if ({ForwardAE, ForwardBE} !== {e.fae, e.fbe}) begin failures++; $display("FAIL z_fwde got=%b exp=%b", {ForwardAE, ForwardBE}, {e.fae, e.fbe}); end
        checks++; if ({ForwardAD, ForwardBD} !== {e.fad, e.fbd}) begin failures++; $display("FAIL z_fwdd got=%b exp=%b", {ForwardAD, ForwardBD}, {e.fad, e.fbd}); end
        next_cycle(e.stall);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_div();
        test_back_to_back();
        test_reset_mid_busy();
        test_zero_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
